quiz_inverse_solver: RTL and testbench
======================================

Name: quiz_inverse_solver

Overview:
Inverse of the power-scale-fold datapath. Given a target byte R and base x, the block searches all 16 coefficient/exponent pairs (A in 0..3, B in 0..3) for those where fold(A * x^B) equals R. It reports the first matching pair in search order and, optionally, the total number of matches. It sits beside the forward Quiz datapath as its decoder/checker and uses a start/busy/done handshake.

Parameters:
STOP_ON_FIRST, 1, 1 = terminate the scan at the first match; 0 = always scan all 16 candidates and count every match.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
target  input  8  R, the value to invert; latched when start is accepted.
x  input  4  base; latched when start is accepted.
busy  output  1  high while scanning (EVAL state).
done  output  1  one-cycle pulse when the result is valid.
found  output  1  at least one match exists; held until the next accepted start.
a_out  output  2  A of the first match; 0 if none; held.
b_out  output  2  B of the first match; 0 if none; held.
match_count  output  5  number of matching pairs (0..16); held. With STOP_ON_FIRST=1 it is 1 on a match, else 0.

Behaviour:
- Forward function (must match the Quiz datapath bit-exactly). Let v = A * x^B, with x^0 = 1, v in 0..10125, held in 14 bits with no truncation. fold(v) = 0 if v == 0; otherwise ((v-1) mod 255) + 1, giving a result in 1..255. This equals repeated subtraction of 255 while v > 255, so fold(255) = 255 and fold(510) = 255.
- The fold may be combinational or a subtractor chain. It must complete within one EVAL cycle; a multicycle fold is not allowed.
- Search order: candidate index idx = 4*B + A. B is the outer loop and A the inner loop, both ascending.
- Registers: p (12 bits) holds x^B; a_cnt and b_cnt (2 bits each); tgt_q and x_q hold the latched inputs.
- State IDLE:
  - busy = 0.
  - On start: latch target and x; set p = 1, a_cnt = 0, b_cnt = 0, match_count = 0, found = 0; go to EVAL.
- State EVAL (busy = 1). Each cycle evaluates exactly one candidate, fold(a_cnt * p) versus tgt_q.
  - On a match: increment match_count. If this is the first match, capture a_out = a_cnt and b_out = b_cnt, and set found = 1.
  - Advance: a_cnt increments. When a_cnt wraps from 3 to 0, p <= p * x_q and b_cnt increments.
  - Leave EVAL after idx 15, or after the first match when STOP_ON_FIRST = 1; go to DONE.
- State DONE: done = 1 for exactly one cycle; then go to IDLE.
- Latency, with the start edge counted as cycle 0:
  - Candidate idx is evaluated in cycle idx+1.
  - done is high in cycle k+2, where k is the last index evaluated.
  - STOP_ON_FIRST = 0: always 17 cycles.
  - STOP_ON_FIRST = 1: 2..17 cycles.
- start while busy or in DONE is ignored. It is not queued and has no effect on latched inputs.
- Outputs found, a_out, b_out and match_count:
  - During a scan they reflect the partial results of the scan in progress.
  - After done they hold their values until the next accepted start clears them.
- Reset (any state, including mid-scan):
  - Next edge: state = IDLE.
  - busy, done, found, a_out, b_out and match_count are all 0.
  - p = 1; all counters are 0.
  - No done pulse is produced for the aborted scan.
- Boundary cases:
  - target = 0 always matches at idx 0 (A = 0).
  - x = 0: p becomes 0 for B >= 1, so target = 0 with STOP_ON_FIRST = 0 gives match_count = 13.
  - p * x_q at B = 3 is not used, so its overflow is irrelevant.

Test Plan:
- STOP_ON_FIRST=1, target=9, x=7 -> done at cycle 17; found=1, a_out=3, b_out=3, match_count=1 (7^3*3 = 1029 folds to 9).
- target=180, x=15 -> a_out=3, b_out=3 (10125 folds to 180); done at cycle 17. Also target=49, x=7 -> a_out=1, b_out=2, done at cycle 11.
- STOP_ON_FIRST=0, target=0, x=0 -> done at cycle 17; found=1, a_out=0, b_out=0, match_count=13. Same with x=5 -> match_count=4.
- No match: target=200, x=2 -> done at cycle 17; found=0, a_out=0, b_out=0, match_count=0.
- Pulse start again at cycle 3 of a scan with a different target/x -> ignored; result matches the first request. done is exactly one cycle wide.
- Assert rst at cycle 5 of a scan -> next cycle busy=0 and all outputs 0; no done pulse. A new start then completes normally.
- Random sweep over (A, B, x): drive target = forward model(A, B, x) -> found=1, and fold(a_out * x^b_out) == target.

Source files
------------

// File: rtl/quiz_inverse_solver.sv
// Inverse power-scale-fold solver: finds the first (A,B) in 0..3 x 0..3 with fold(A * x^B) == target.
// Latency: start edge is cycle 0, candidate idx evaluated in cycle idx+1, done high in cycle k+2 (k = last idx).
// Backpressure: none; start is only accepted in IDLE and is silently dropped while busy or done.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, target, x    - request pulse plus value to invert and base (latched on accepted start)
//   busy, done          - scanning indicator, one-cycle result-valid pulse
//   found, a_out, b_out - first match flag and its coefficient/exponent (held until next start)
//   match_count         - number of matching pairs seen in the scan

module quiz_inverse_solver #(
   parameter bit STOP_ON_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] target,
   input  logic [3:0] x,
   output logic       busy,
   output logic       done,
   output logic       found,
   output logic [1:0] a_out,
   output logic [1:0] b_out,
   output logic [4:0] match_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [7:0]  tgt_q;
   logic [3:0]  x_q;
   logic [11:0] p;
   logic [1:0]  a_cnt;
   logic [1:0]  b_cnt;

   logic [13:0] v;
   logic [13:0] v_m1;
   logic [13:0] rem;
   logic [7:0]  fold_v;
   logic        hit;
   logic        last;
   logic [15:0] p_next;

   // Forward datapath for the current candidate. v never exceeds 3*15^3 = 10125,
   // so 14 bits hold it exactly. fold maps 1..255 onto itself and wraps every 255 above.
   always_comb begin
      v      = 14'(a_cnt) * 14'(p);
      v_m1   = v - 14'd1;
      rem    = v_m1 % 14'd255;
      fold_v = (v == 14'd0) ? 8'd0 : (rem[7:0] + 8'd1);
      hit    = (fold_v == tgt_q);
      last   = ((a_cnt == 2'd3) && (b_cnt == 2'd3)) || (STOP_ON_FIRST && hit);
      // Only the low 12 bits are kept; the product after B = 3 is never used.
      p_next = 16'(p) * 16'(x_q);
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = EVAL;
         end
         EVAL: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tgt_q       <= 8'd0;
         x_q         <= 4'd0;
         p           <= 12'd1;
         a_cnt       <= 2'd0;
         b_cnt       <= 2'd0;
         found       <= 1'b0;
         a_out       <= 2'd0;
         b_out       <= 2'd0;
         match_count <= 5'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  tgt_q       <= target;
                  x_q         <= x;
                  p           <= 12'd1;
                  a_cnt       <= 2'd0;
                  b_cnt       <= 2'd0;
                  found       <= 1'b0;
                  a_out       <= 2'd0;
                  b_out       <= 2'd0;
                  match_count <= 5'd0;
               end
            end
            EVAL: begin
               if (hit) begin
                  match_count <= match_count + 5'd1;
                  // found doubles as the "first match already captured" flag.
                  if (!found) begin
                     found <= 1'b1;
                     a_out <= a_cnt;
                     b_out <= b_cnt;
                  end
               end
               a_cnt <= a_cnt + 2'd1;
               if (a_cnt == 2'd3) begin
                  p     <= p_next[11:0];
                  b_cnt <= b_cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quiz_inverse_solver.sv
// Directed bench for quiz_inverse_solver, driving a stop-on-first and a full-scan instance in parallel.
module tb_quiz_inverse_solver;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] target;
   logic [3:0] x;

   logic       f_busy, f_done, f_found;
   logic [1:0] f_a, f_b;
   logic [4:0] f_mc;
   logic       s_busy, s_done, s_found;
   logic [1:0] s_a, s_b;
   logic [4:0] s_mc;

   int compared = 0;
   int mismatched = 0;

   quiz_inverse_solver #(.STOP_ON_FIRST(1'b1)) u_first (
      .clk(clk), .rst(rst), .start(start), .target(target), .x(x),
      .busy(f_busy), .done(f_done), .found(f_found),
      .a_out(f_a), .b_out(f_b), .match_count(f_mc)
   );

   quiz_inverse_solver #(.STOP_ON_FIRST(1'b0)) u_all (
      .clk(clk), .rst(rst), .start(start), .target(target), .x(x),
      .busy(s_busy), .done(s_done), .found(s_found),
      .a_out(s_a), .b_out(s_b), .match_count(s_mc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int fold_m(input int v);
      int r;
      if (v == 0) return 0;
      r = v;
      while (r > 255) r -= 255;
      return r;
   endfunction

   function automatic int pw(input int b, input int e);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) r = r * b;
      return r;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue a request and watch both instances for 20 cycles (cycle n sampled at the
   // negedge inside it). Optionally pulse a competing start in cycle inj.
   task automatic run(input int t, input int xx, input int inj,
                      output int dc1, output int w1, output int dc0, output int w0);
      dc1 = 0; w1 = 0; dc0 = 0; w0 = 0;
      target = 8'(t);
      x      = 4'(xx);
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (f_done === 1'b1) begin
            if (dc1 == 0) dc1 = c;
            w1++;
         end
         if (s_done === 1'b1) begin
            if (dc0 == 0) dc0 = c;
            w0++;
         end
         if (c == inj) begin
            start  = 1'b1;
            target = 8'd0;
            x      = 4'd3;
         end
         if (c == inj + 1) start = 1'b0;
      end
   endtask

   task automatic chk_inst(input string tag, input bit first, input int dc, input int w,
                           input int edc, input int ef, input int ea, input int eb, input int emc);
      chk({tag, " done_cycle"}, dc, edc);
      chk({tag, " done_width"}, w, (edc == 0) ? 0 : 1);
      chk({tag, " found"}, first ? int'(f_found) : int'(s_found), ef);
      chk({tag, " a_out"}, first ? int'(f_a) : int'(s_a), ea);
      chk({tag, " b_out"}, first ? int'(f_b) : int'(s_b), eb);
      chk({tag, " match_count"}, first ? int'(f_mc) : int'(s_mc), emc);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " f_busy"},  int'(f_busy),  0);
      chk({tag, " f_done"},  int'(f_done),  0);
      chk({tag, " f_found"}, int'(f_found), 0);
      chk({tag, " f_ab"},    int'({f_a, f_b}), 0);
      chk({tag, " f_mc"},    int'(f_mc),    0);
      chk({tag, " s_busy"},  int'(s_busy),  0);
      chk({tag, " s_done"},  int'(s_done),  0);
      chk({tag, " s_found"}, int'(s_found), 0);
      chk({tag, " s_ab"},    int'({s_a, s_b}), 0);
      chk({tag, " s_mc"},    int'(s_mc),    0);
   endtask

   initial begin
      int d1, w1, d0, w0, cnt;
      int ra, rb, rx, rt;

      rst = 1'b1; start = 1'b0; target = 8'd0; x = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // 3*7^3 = 1029 folds to 9, the only hit, at idx 15.
      run(9, 7, 0, d1, w1, d0, w0);
      chk_inst("t9x7 first", 1'b1, d1, w1, 17, 1, 3, 3, 1);
      chk_inst("t9x7 all",   1'b0, d0, w0, 17, 1, 3, 3, 1);

      // 3*15^3 = 10125 folds to 180.
      run(180, 15, 0, d1, w1, d0, w0);
      chk_inst("t180x15 first", 1'b1, d1, w1, 17, 1, 3, 3, 1);
      chk_inst("t180x15 all",   1'b0, d0, w0, 17, 1, 3, 3, 1);

      // 1*7^2 = 49 at idx 9: early exit at cycle 11.
      run(49, 7, 0, d1, w1, d0, w0);
      chk_inst("t49x7 first", 1'b1, d1, w1, 11, 1, 1, 2, 1);
      chk_inst("t49x7 all",   1'b0, d0, w0, 17, 1, 1, 2, 1);

      // target 0, x 0: idx 0 plus all of B = 1..3.
      run(0, 0, 0, d1, w1, d0, w0);
      chk_inst("t0x0 first", 1'b1, d1, w1, 2, 1, 0, 0, 1);
      chk_inst("t0x0 all",   1'b0, d0, w0, 17, 1, 0, 0, 13);

      // target 0, x 5: only A = 0 for each B.
      run(0, 5, 0, d1, w1, d0, w0);
      chk_inst("t0x5 first", 1'b1, d1, w1, 2, 1, 0, 0, 1);
      chk_inst("t0x5 all",   1'b0, d0, w0, 17, 1, 0, 0, 4);

      // No match anywhere.
      run(200, 2, 0, d1, w1, d0, w0);
      chk_inst("t200x2 first", 1'b1, d1, w1, 17, 0, 0, 0, 0);
      chk_inst("t200x2 all",   1'b0, d0, w0, 17, 0, 0, 0, 0);

      // Competing start (target 0, x 3) in cycle 3 must be dropped.
      run(49, 7, 3, d1, w1, d0, w0);
      chk_inst("ignore first", 1'b1, d1, w1, 11, 1, 1, 2, 1);
      chk_inst("ignore all",   1'b0, d0, w0, 17, 1, 1, 2, 1);

      // Reset during a scan that already has a partial result in the full-scan instance.
      target = 8'd0; x = 4'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre-reset s_busy", int'(s_busy), 1);
      chk("pre-reset s_found", int'(s_found), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_zero("midscan reset");
      rst = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (f_done === 1'b1 || s_done === 1'b1) cnt++;
      end
      chk("no done after abort", cnt, 0);
      run(49, 7, 0, d1, w1, d0, w0);
      chk_inst("post-reset first", 1'b1, d1, w1, 11, 1, 1, 2, 1);
      chk_inst("post-reset all",   1'b0, d0, w0, 17, 1, 1, 2, 1);

      // Random targets drawn from the forward model must be invertible.
      for (int i = 0; i < 8; i++) begin
         ra = $urandom_range(0, 3);
         rb = $urandom_range(0, 3);
         rx = $urandom_range(0, 15);
         rt = fold_m(ra * pw(rx, rb));
         run(rt, rx, 0, d1, w1, d0, w0);
         chk("rand first found", int'(f_found), 1);
         chk("rand first inverse", fold_m(int'(f_a) * pw(rx, int'(f_b))), rt);
         chk("rand first width", w1, 1);
         chk("rand all found", int'(s_found), 1);
         chk("rand all inverse", fold_m(int'(s_a) * pw(rx, int'(s_b))), rt);
         chk("rand all done_cycle", d0, 17);
         chk("rand agree a", int'(s_a), int'(f_a));
         chk("rand agree b", int'(s_b), int'(f_b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
